// File: rtl/wowi_burst_adapter_if.sv
// rtl/wowi_burst_adapter_if.sv - request, write, read and BRAM signal bundle for the burst adapter
interface wowi_burst_adapter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 4
);
    logic                             req_valid;
    logic                             req_ready;
    logic                             req_write;
    logic [ADDR_WIDTH-1:0]            req_addr;
    logic [LEN_WIDTH-1:0]             req_len;
    logic                             wr_valid;
    logic                             wr_ready;
    logic [WORD_BYTES*DATA_WIDTH-1:0] wr_data;
    logic [WORD_BYTES-1:0]            wr_be;
    logic [WORD_BYTES*DATA_WIDTH-1:0] rd_data;
    logic                             rd_valid;
    logic                             done;
    logic [ADDR_WIDTH-1:0]            bram_addr;
    logic [DATA_WIDTH-1:0]            bram_din;
    logic                             bram_we;
    logic [DATA_WIDTH-1:0]            bram_dout;

    modport slave (
        input  req_valid, req_write, req_addr, req_len,
        input  wr_valid, wr_data, wr_be, bram_dout,
        output req_ready, wr_ready, rd_data, rd_valid, done,
        output bram_addr, bram_din, bram_we
    );

    modport master (
        output req_valid, req_write, req_addr, req_len,
        output wr_valid, wr_data, wr_be, bram_dout,
        input  req_ready, wr_ready, rd_data, rd_valid, done,
        input  bram_addr, bram_din, bram_we
    );
endinterface

// File: rtl/wowi_burst_adapter.sv
// rtl/wowi_burst_adapter.sv - word burst to byte-serial single-port BRAM adapter
module wowi_burst_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    wowi_burst_adapter_if.slave bus
);
    localparam int WW = WORD_BYTES * DATA_WIDTH;
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BW-1:0] LAST_B = BW'(WORD_BYTES - 1);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DRAIN, WR_WAIT, WR_BYTES} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [ADDR_WIDTH-1:0] off;
    logic [LEN_WIDTH-1:0]  lat_len;
    logic [LEN_WIDTH-1:0]  wcnt;
    logic [LEN_WIDTH-1:0]  cap_wcnt;
    logic [BW-1:0]         bcnt;
    logic [BW-1:0]         cap_bcnt;
    logic [WW-1:0]         wr_word;
    logic [WORD_BYTES-1:0] wr_mask;
    logic [WW-1:0]         rd_buf;
    logic [WW-1:0]         rd_asm;
    logic                  issue_q;
    logic [RD_LATENCY-1:0] tag_sr;

    logic                  issue_rd;
    logic                  write_byte;
    logic                  seq_last;
    logic                  cap_fire;
    logic                  cap_word_end;
    logic                  cap_final;
    logic [LEN_WIDTH-1:0]  len_eff;
    logic [ADDR_WIDTH-1:0] byte_addr;
    logic [DATA_WIDTH-1:0] byte_data;
    logic                  byte_we;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: a burst ends when the last byte is issued/written, reads then drain
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_write)  state_nxt = WR_WAIT;
                    else if (seq_last)  state_nxt = RD_DRAIN;
                    else                state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE: if (seq_last)  state_nxt = RD_DRAIN;
            RD_DRAIN: if (cap_final) state_nxt = IDLE;
            WR_WAIT, WR_BYTES: begin
                if (write_byte) begin
                    if (bcnt != LAST_B) state_nxt = WR_BYTES;
                    else                state_nxt = seq_last ? IDLE : WR_WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs and per-cycle byte decode; byte 0 of a read is issued in IDLE itself
    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.wr_ready  = (state == WR_WAIT);
        issue_rd      = (state == RD_ISSUE) || ((state == IDLE) && bus.req_valid && !bus.req_write);
        write_byte    = (state == WR_BYTES) || ((state == WR_WAIT) && bus.wr_valid);
        len_eff       = (state == IDLE) ? bus.req_len : lat_len;
        seq_last      = (bcnt == LAST_B) && (wcnt == len_eff);
        byte_addr     = ((state == IDLE) ? bus.req_addr : lat_addr) + off;
        byte_data     = (state == WR_WAIT) ? bus.wr_data[DATA_WIDTH-1:0] : wr_word[DATA_WIDTH-1:0];
        byte_we       = (state == WR_WAIT) ? bus.wr_be[0] : wr_mask[0];
        cap_fire      = tag_sr[RD_LATENCY-1];
        cap_word_end  = cap_fire && (cap_bcnt == LAST_B);
        cap_final     = cap_word_end && (cap_wcnt == lat_len);
        rd_asm        = rd_buf;
        rd_asm[int'(cap_bcnt)*DATA_WIDTH +: DATA_WIDTH] = bus.bram_dout;
    end

    // Issue side: request latch, byte/word counters, BRAM port registers, write word shifter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_addr      <= '0;
            lat_len       <= '0;
            off           <= '0;
            bcnt          <= '0;
            wcnt          <= '0;
            wr_word       <= '0;
            wr_mask       <= '0;
            bus.bram_addr <= '0;
            bus.bram_din  <= '0;
            bus.bram_we   <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.req_valid) begin
                lat_addr <= bus.req_addr;
                lat_len  <= bus.req_len;
            end
            if (issue_rd || write_byte) begin
                bus.bram_addr <= byte_addr;
                if (seq_last) begin
                    off  <= '0;
                    bcnt <= '0;
                    wcnt <= '0;
                end else begin
                    off <= off + 1'b1;
                    if (bcnt == LAST_B) begin
                        bcnt <= '0;
                        wcnt <= wcnt + 1'b1;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
            end
            if (write_byte) bus.bram_din <= byte_data;
            bus.bram_we <= write_byte && byte_we;
            if ((state == WR_WAIT) && bus.wr_valid) begin
                wr_word <= bus.wr_data >> DATA_WIDTH;
                wr_mask <= bus.wr_be >> 1;
            end else if (state == WR_BYTES) begin
                wr_word <= wr_word >> DATA_WIDTH;
                wr_mask <= wr_mask >> 1;
            end
        end
    end

    // Read capture: tag pipeline tracks BRAM latency, bytes assemble in rd_buf, word published whole
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_q      <= 1'b0;
            tag_sr       <= '0;
            cap_bcnt     <= '0;
            cap_wcnt     <= '0;
            rd_buf       <= '0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            issue_q      <= issue_rd;
            tag_sr       <= RD_LATENCY'({tag_sr, issue_q});
            bus.rd_valid <= cap_word_end;
            bus.done     <= (write_byte && seq_last) || cap_final;
            if (cap_fire) begin
                rd_buf <= rd_asm;
                if (cap_word_end) begin
                    bus.rd_data <= rd_asm;
                    cap_bcnt    <= '0;
                    cap_wcnt    <= cap_final ? '0 : cap_wcnt + 1'b1;
                end else begin
                    cap_bcnt <= cap_bcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_wowi_burst_adapter.sv
// tb/tb_wowi_burst_adapter.sv - directed table and sequence checks for wowi_burst_adapter
`timescale 1ns/1ps
module tb_wowi_burst_adapter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wowi_burst_adapter_if #(.DATA_WIDTH(8), .WORD_BYTES(4), .ADDR_WIDTH(10), .LEN_WIDTH(4)) b1 ();
    wowi_burst_adapter_if #(.DATA_WIDTH(8), .WORD_BYTES(4), .ADDR_WIDTH(10), .LEN_WIDTH(4)) b3 ();

    wowi_burst_adapter #(.DATA_WIDTH(8), .WORD_BYTES(4), .ADDR_WIDTH(10), .RD_LATENCY(1), .LEN_WIDTH(4))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    wowi_burst_adapter #(.DATA_WIDTH(8), .WORD_BYTES(4), .ADDR_WIDTH(10), .RD_LATENCY(3), .LEN_WIDTH(4))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    logic [7:0] mem1 [1024];
    logic [7:0] mem3 [1024];
    logic [7:0] dout1;
    logic [7:0] p3 [3];
    assign b1.bram_dout = dout1;
    assign b3.bram_dout = p3[2];

    function automatic logic [7:0] init1(input int i);
        case (i)
            'h010: return 8'h11;  'h011: return 8'h22;  'h012: return 8'h33;  'h013: return 8'h44;
            'h040: return 8'hA0;  'h041: return 8'hA1;  'h042: return 8'hA2;  'h043: return 8'hA3;
            'h3FE: return 8'h5E;  'h3FF: return 8'h5F;  'h000: return 8'h60;  'h001: return 8'h61;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] init3(input int i);
        if (i >= 'h100 && i < 'h10C) return 8'(i - 'hFF);
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= init1(i);
        end else if (b1.bram_we === 1'b1) begin
            mem1[b1.bram_addr] <= b1.bram_din;
        end
        dout1 <= mem1[b1.bram_addr];
    end

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) mem3[i] <= init3(i);
        end else if (b3.bram_we === 1'b1) begin
            mem3[b3.bram_addr] <= b3.bram_din;
        end
        p3[0] <= mem3[b3.bram_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    typedef struct { logic [9:0] a; logic [7:0] d; int c; } wlog_t;
    wlog_t wlog [$];
    always @(posedge clk) if (b1.bram_we === 1'b1) wlog.push_back('{b1.bram_addr, b1.bram_din, cyc});

    typedef struct { bit wr; logic [9:0] addr; logic [31:0] data; logic [3:0] be; logic [31:0] exp; } vec_t;
    vec_t vecs [10];

    logic [31:0] wr_words [4];
    logic [31:0] rd_words [4];
    int          rd_vc [4];
    int          rd_nv;
    int          op_done;
    logic [9:0]  trace [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_read(input logic [9:0] a, input logic [3:0] len);
        int c;
        rd_nv = 0;
        op_done = -1;
        for (int k = 0; k < 4; k++) begin rd_words[k] = '0; rd_vc[k] = -1; end
        b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_addr = a; b1.req_len = len;
        step();
        b1.req_valid = 1'b0;
        c = 0;
        while (c < 64) begin
            if (c < 16) trace[c] = b1.bram_addr;
            if (b1.rd_valid) begin
                if (rd_nv < 4) begin rd_words[rd_nv] = b1.rd_data; rd_vc[rd_nv] = c; end
                rd_nv++;
            end
            if (b1.done) begin op_done = c; break; end
            step();
            c++;
        end
    endtask

    task automatic run_write(input logic [9:0] a, input logic [3:0] len, input logic [3:0] be);
        int   c;
        int   i;
        logic acc;
        op_done = -1;
        b1.req_valid = 1'b1; b1.req_write = 1'b1; b1.req_addr = a; b1.req_len = len;
        step();
        b1.req_valid = 1'b0;
        i = 0;
        b1.wr_valid = 1'b1; b1.wr_data = wr_words[0]; b1.wr_be = be;
        c = 0;
        while (c < 64) begin
            if (b1.done) begin op_done = c; break; end
            acc = b1.wr_valid && b1.wr_ready;
            step();
            c++;
            if (acc) begin
                i++;
                if (i > int'(len)) b1.wr_valid = 1'b0;
                else               b1.wr_data  = wr_words[i];
            end
        end
        b1.wr_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [39:0] tr_act;
        logic [39:0] tr_exp;
        logic [9:0]  ta;
        logic [7:0]  sbytes [8];
        logic [31:0] w3 [3];
        logic [31:0] hold3;
        int          v3 [3];
        int          c, nv3, done3, busy_bad, bad, n0, done_seen;

        vecs[0] = '{1'b0, 10'h010, 32'h0,        4'h0, 32'h44332211};
        vecs[1] = '{1'b1, 10'h040, 32'hFFEEDDCC, 4'h5, 32'd2};
        vecs[2] = '{1'b0, 10'h040, 32'h0,        4'h0, 32'hA3EEA1CC};
        vecs[3] = '{1'b0, 10'h3FE, 32'h0,        4'h0, 32'h61605F5E};
        vecs[4] = '{1'b1, 10'h080, 32'h12345678, 4'hF, 32'd4};
        vecs[5] = '{1'b0, 10'h080, 32'h0,        4'h0, 32'h12345678};
        vecs[6] = '{1'b1, 10'h084, 32'hDEADBEEF, 4'h8, 32'd1};
        vecs[7] = '{1'b0, 10'h084, 32'h0,        4'h0, 32'hDE000000};
        vecs[8] = '{1'b1, 10'h010, 32'hCAFEF00D, 4'h0, 32'd0};
        vecs[9] = '{1'b0, 10'h010, 32'h0,        4'h0, 32'h44332211};

        b1.req_valid = 0; b1.req_write = 0; b1.req_addr = 0; b1.req_len = 0;
        b1.wr_valid = 0; b1.wr_data = 0; b1.wr_be = 0;
        b3.req_valid = 0; b3.req_write = 0; b3.req_addr = 0; b3.req_len = 0;
        b3.wr_valid = 0; b3.wr_data = 0; b3.wr_be = 0;

        rst_n = 1'b0;
        repeat (3) step();
        check("reset req_ready", b1.req_ready, 1);
        check("reset wr_ready", b1.wr_ready, 0);
        check("reset rd_valid", b1.rd_valid, 0);
        check("reset done", b1.done, 0);
        check("reset rd_data", b1.rd_data, 0);
        check("reset bram_addr", b1.bram_addr, 0);
        check("reset bram_din", b1.bram_din, 0);
        check("reset bram_we", b1.bram_we, 0);
        rst_n = 1'b1;
        repeat (2) step();

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].wr) begin
                wlog.delete();
                wr_words[0] = vecs[v].data;
                run_write(vecs[v].addr, 4'd0, vecs[v].be);
                check($sformatf("vec%0d write done cycle", v), op_done, 4);
                step();
                check($sformatf("vec%0d bram_we count", v), wlog.size(), vecs[v].exp);
            end else begin
                run_read(vecs[v].addr, 4'd0);
                check($sformatf("vec%0d rd_data", v), rd_words[0], vecs[v].exp);
                check($sformatf("vec%0d rd_valid count", v), rd_nv, 1);
                check($sformatf("vec%0d rd_valid cycle", v), rd_vc[0], 5);
                check($sformatf("vec%0d done cycle", v), op_done, 5);
                tr_act = {trace[0], trace[1], trace[2], trace[3]};
                ta = vecs[v].addr;
                tr_exp = {ta, ta + 10'd1, ta + 10'd2, ta + 10'd3};
                check($sformatf("vec%0d bram_addr trace", v), tr_act, tr_exp);
            end
            step();
            check($sformatf("vec%0d idle after done", v), {b1.req_ready, b1.done}, 2'b10);
        end

        run_read(10'h3FE, 4'd0);
        check("wrap bram_addr order", {trace[0], trace[1], trace[2], trace[3]},
              {10'h3FE, 10'h3FF, 10'h000, 10'h001});
        check("wrap rd_data", rd_words[0], 32'h61605F5E);
        step();

        wlog.delete();
        wr_words[0] = 32'hAABBCCDD;
        wr_words[1] = 32'h01020304;
        sbytes[0] = 8'hDD; sbytes[1] = 8'hCC; sbytes[2] = 8'hBB; sbytes[3] = 8'hAA;
        sbytes[4] = 8'h04; sbytes[5] = 8'h03; sbytes[6] = 8'h02; sbytes[7] = 8'h01;
        run_write(10'h020, 4'd1, 4'hF);
        check("stream done cycle", op_done, 8);
        step();
        check("stream bram_we count", wlog.size(), 8);
        if (wlog.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("stream byte%0d addr/data/slot", i),
                      {wlog[i].a, wlog[i].d, 8'(wlog[i].c - wlog[0].c)},
                      {10'h020 + 10'(i), sbytes[i], 8'(i)});
            end
        end
        check("stream req_ready after done", {b1.req_ready, b1.done}, 2'b10);
        step();

        check("lat3 idle ready", b3.req_ready, 1);
        b3.req_valid = 1'b1; b3.req_write = 1'b0; b3.req_addr = 10'h100; b3.req_len = 4'd2;
        step();
        b3.req_valid = 1'b0;
        c = 0; nv3 = 0; done3 = -1; busy_bad = 0; hold3 = '0;
        for (int k = 0; k < 3; k++) begin w3[k] = '0; v3[k] = -1; end
        while (c < 80) begin
            if (b3.rd_valid) begin
                if (nv3 < 3) begin w3[nv3] = b3.rd_data; v3[nv3] = c; end
                nv3++;
            end
            if (c == 9) hold3 = b3.rd_data;
            if (b3.done) begin done3 = c; break; end
            if (b3.req_ready) busy_bad++;
            step();
            c++;
        end
        check("lat3 rd_valid count", nv3, 3);
        check("lat3 pulse cycles", {8'(v3[0]), 8'(v3[1]), 8'(v3[2])}, {8'd7, 8'd11, 8'd15});
        check("lat3 word0", w3[0], 32'h04030201);
        check("lat3 word1", w3[1], 32'h08070605);
        check("lat3 word2", w3[2], 32'h0C0B0A09);
        check("lat3 rd_data hold", hold3, 32'h04030201);
        check("lat3 done with last pulse", done3, 15);
        check("lat3 req_ready low while busy", busy_bad, 0);
        step();

        wlog.delete();
        b1.req_valid = 1'b1; b1.req_write = 1'b1; b1.req_addr = 10'h200; b1.req_len = 4'd3;
        step();
        b1.req_valid = 1'b0;
        b1.wr_valid = 1'b1; b1.wr_data = 32'h55667788; b1.wr_be = 4'hF;
        repeat (6) step();
        check("rst writes in flight", wlog.size() > 0, 1);
        rst_n = 1'b0;
        bad = 0;
        n0 = 0;
        for (int r = 0; r < 3; r++) begin
            step();
            if (r == 0) n0 = wlog.size();
            if (b1.bram_we !== 1'b0 || b1.done !== 1'b0) bad++;
        end
        check("rst we/done low", bad, 0);
        rst_n = 1'b1;
        step();
        check("rst req_ready after release", b1.req_ready, 1);
        check("rst wr_ready after release", b1.wr_ready, 0);
        done_seen = 0;
        repeat (10) begin
            step();
            if (b1.done !== 1'b0) done_seen++;
        end
        check("rst no further writes", wlog.size(), n0);
        check("rst no done", done_seen, 0);
        b1.wr_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
